// File: rtl/game_state_ctrl_pkg.sv
// Shared state codes and frame counter helpers for the game sequencer.
// State codes match the display multiplexer decode.
package game_state_ctrl_pkg;

  localparam int FC_W = 8;

  typedef enum logic [2:0] {
    ST_TITLE = 3'b000,
    ST_INTRO = 3'b001,
    ST_READY = 3'b010,
    ST_PLAY  = 3'b011,
    ST_FLASH = 3'b100,
    ST_OVER  = 3'b101
  } state_e;

  // A zero frame count behaves as one frame.
  function automatic logic [FC_W-1:0] fr_min(int n);
    if (n < 1) return FC_W'(1);
    if (n > 255) return '1;
    return FC_W'(n);
  endfunction

  function automatic logic [FC_W-1:0] fr_last(int n);
    return fr_min(n) - FC_W'(1);
  endfunction

endpackage

// File: rtl/game_state_ctrl_btn_sync_edge.sv
// Two-flop synchronizer plus registered rising-edge detect.
// btn_rise pulses one clk, three clks after btn_raw rises.
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_rise
);

  logic [2:0] sync_q, sync_d;
  logic       rise_q, rise_d;

  always_comb begin
    sync_d = {sync_q[1:0], btn_raw};
    rise_d = sync_q[1] & ~sync_q[2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      rise_q <= rise_d;
    end
  end

  assign btn_rise = rise_q;

endmodule

// File: rtl/game_state_ctrl.sv
// Game sequencer: title/intro/ready/play/flash/over with registered outputs.
// Optional best-score tracking under BEST_SCORE_EN.
module game_state_ctrl
  import game_state_ctrl_pkg::*;
#(
  parameter int INTRO_FRAMES   = 60,
  parameter int FLASH_FRAMES   = 30,
  parameter int LOCKOUT_FRAMES = 45
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       btn_raw,
  input  logic       collision,
  input  logic [7:0] score,
  output logic [2:0] state,
  output logic       bird_run,
  output logic       pipe_run,
  output logic       flap_pulse,
  output logic       score_clr,
  output logic [7:0] best_score,
  output logic       new_best
);

  localparam logic [FC_W-1:0] INTRO_LAST = fr_last(INTRO_FRAMES);
  localparam logic [FC_W-1:0] FLASH_LAST = fr_last(FLASH_FRAMES);
  localparam logic [FC_W-1:0] LOCK_MIN   = fr_min(LOCKOUT_FRAMES);

  logic            btn_rise;
  logic [2:0]      state_q, state_d;
  logic [FC_W-1:0] cnt_q, cnt_d;
  logic            bird_q, bird_d;
  logic            pipe_q, pipe_d;
  logic            flap_q, flap_d;
  logic            clr_q, clr_d;

  btn_sync_edge u_btn (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_raw  (btn_raw),
    .btn_rise (btn_rise)
  );

  always_comb begin
    state_d = state_q;
    flap_d  = 1'b0;
    clr_d   = 1'b0;
    unique case (state_q)
      ST_TITLE: if (btn_rise) begin
        state_d = ST_INTRO;
        clr_d   = 1'b1;
      end
      ST_INTRO:
        if (frame_tick && cnt_q == INTRO_LAST)
          state_d = ST_READY;
      ST_READY: if (btn_rise) begin
        state_d = ST_PLAY;
        flap_d  = 1'b1;
      end
      ST_PLAY:
        if (collision) state_d = ST_FLASH;
        else if (btn_rise) flap_d = 1'b1;
      ST_FLASH:
        if (frame_tick && cnt_q == FLASH_LAST)
          state_d = ST_OVER;
      ST_OVER:
        if (btn_rise && cnt_q >= LOCK_MIN) begin
          state_d = ST_TITLE;
          clr_d   = 1'b1;
        end
      default: state_d = ST_TITLE;
    endcase

    if (state_d != state_q) cnt_d = '0;
    else if (frame_tick && cnt_q != '1) cnt_d = cnt_q + 1'b1;
    else cnt_d = cnt_q;

    bird_d = (state_d == ST_PLAY) || (state_d == ST_FLASH);
    pipe_d = (state_d == ST_PLAY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_TITLE;
      cnt_q   <= '0;
      bird_q  <= 1'b0;
      pipe_q  <= 1'b0;
      flap_q  <= 1'b0;
      clr_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bird_q  <= bird_d;
      pipe_q  <= pipe_d;
      flap_q  <= flap_d;
      clr_q   <= clr_d;
    end
  end

  assign state      = state_q;
  assign bird_run   = bird_q;
  assign pipe_run   = pipe_q;
  assign flap_pulse = flap_q;
  assign score_clr  = clr_q;

`ifdef BEST_SCORE_EN
  logic [7:0] best_q, best_d;
  logic       nb_q, nb_d;

  always_comb begin
    best_d = best_q;
    nb_d   = nb_q;
    if (state_d == ST_OVER && state_q != ST_OVER) begin
      nb_d = 1'b0;
      if (score > best_q) begin
        best_d = score;
        nb_d   = 1'b1;
      end
    end else if (state_d != ST_OVER) begin
      nb_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_q <= '0;
      nb_q   <= 1'b0;
    end else begin
      best_q <= best_d;
      nb_q   <= nb_d;
    end
  end

  assign best_score = best_q;
  assign new_best   = nb_q;
`else
  logic unused_score;
  assign unused_score = ^score;
  assign best_score   = '0;
  assign new_best     = 1'b0;
`endif

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl (INTRO=3, FLASH=2, LOCKOUT=2).
// Best-score checks follow BEST_SCORE_EN.
module tb_game_state_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       btn_raw = 1'b0;
  logic       collision = 1'b0;
  logic [7:0] score = '0;
  logic [2:0] state;
  logic       bird_run, pipe_run, flap_pulse, score_clr;
  logic [7:0] best_score;
  logic       new_best;

  int n_cmp = 0;
  int n_bad = 0;

  game_state_ctrl #(
    .INTRO_FRAMES  (3),
    .FLASH_FRAMES  (2),
    .LOCKOUT_FRAMES(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .frame_tick(frame_tick),
    .btn_raw   (btn_raw),
    .collision (collision),
    .score     (score),
    .state     (state),
    .bird_run  (bird_run),
    .pipe_run  (pipe_run),
    .flap_pulse(flap_pulse),
    .score_clr (score_clr),
    .best_score(best_score),
    .new_best  (new_best)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  // Press and wait until the registered rise is about to be consumed.
  task automatic btn_dn();
    btn_raw = 1'b1;
    repeat (3) step();
  endtask

  task automatic btn_up();
    btn_raw = 1'b0;
    repeat (3) step();
  endtask

  task automatic to_play();
    btn_dn(); step(); btn_up();
    repeat (3) tick();
    btn_dn(); step(); btn_up();
  endtask

  task automatic to_over(input logic [7:0] sc);
    score = sc;
    btn_dn();
    collision = 1'b1;
    step();
    collision = 1'b0;
    btn_up();
    tick(); tick();
  endtask

  task automatic to_title();
    tick(); tick();
    btn_dn(); step(); btn_up();
  endtask

  initial begin
    step();
    chk("rst_state", state, 3'b000);
    chk("rst_clr", score_clr, 1);
    chk("rst_bird", bird_run, 0);
    chk("rst_pipe", pipe_run, 0);
    chk("rst_flap", flap_pulse, 0);
    chk("rst_best", best_score, 0);
    rst_n = 1'b1;
    step();
    chk("clr_release", score_clr, 0);

    btn_dn();
    chk("title_wait", state, 3'b000);
    step();
    chk("intro_enter", state, 3'b001);
    chk("start_clr", score_clr, 1);
    step();
    chk("start_clr_end", score_clr, 0);
    btn_up();

    btn_dn(); step();
    chk("intro_btn_ign", state, 3'b001);
    btn_up();
    tick(); tick();
    chk("intro_2tick", state, 3'b001);
    tick();
    chk("ready_enter", state, 3'b010);

    btn_dn();
    chk("ready_wait", state, 3'b010);
    step();
    chk("play_enter", state, 3'b011);
    chk("play_flap", flap_pulse, 1);
    chk("play_pipe", pipe_run, 1);
    chk("play_bird", bird_run, 1);
    step();
    chk("flap_once", flap_pulse, 0);
    repeat (4) step();
    chk("flap_hold", flap_pulse, 0);
    btn_up();

    btn_dn(); step();
    chk("play_flap2", flap_pulse, 1);
    chk("play_hold", state, 3'b011);
    btn_up();

    score = 8'd5;
    btn_dn();
    collision = 1'b1;
    step();
    collision = 1'b0;
    chk("coll_state", state, 3'b100);
    chk("coll_noflap", flap_pulse, 0);
    chk("coll_pipe", pipe_run, 0);
    chk("coll_bird", bird_run, 1);
    btn_up();
    tick();
    chk("flash_1tick", state, 3'b100);
    tick();
    chk("over_enter", state, 3'b101);
    chk("over_bird", bird_run, 0);
`ifdef BEST_SCORE_EN
    chk("best_run1", best_score, 8'd5);
    chk("nb_run1", new_best, 1);
`else
    chk("best_tied", best_score, 0);
    chk("nb_tied", new_best, 0);
`endif

    tick();
    btn_dn(); step();
    chk("lockout_ign", state, 3'b101);
    btn_up();
    tick();
    btn_dn(); step();
    chk("over_exit", state, 3'b000);
    chk("over_clr", score_clr, 1);
    chk("nb_cleared", new_best, 0);
    btn_up();

    to_play();
    to_over(8'd3);
    chk("over_run2", state, 3'b101);
`ifdef BEST_SCORE_EN
    chk("best_run2", best_score, 8'd5);
    chk("nb_run2", new_best, 0);
`else
    chk("best_run2", best_score, 0);
`endif
    to_title();
    to_play();
    to_over(8'd9);
`ifdef BEST_SCORE_EN
    chk("best_run3", best_score, 8'd9);
    chk("nb_run3", new_best, 1);
`else
    chk("nb_run3", new_best, 0);
`endif
    to_title();
    chk("title_again", state, 3'b000);

    force dut.state_q = 3'b111;
    #1;
    chk("illegal_seen", state, 3'b111);
    release dut.state_q;
    step();
    chk("illegal_exit", state, 3'b000);
    chk("illegal_pipe", pipe_run, 0);

    to_play();
    chk("pre_rst_play", state, 3'b011);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", state, 3'b000);
    chk("arst_bird", bird_run, 0);
    chk("arst_pipe", pipe_run, 0);
    chk("arst_flap", flap_pulse, 0);
    chk("arst_clr", score_clr, 1);
    chk("arst_best", best_score, 0);
    chk("arst_nb", new_best, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst", state, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
